// File: rtl/intpol2_job_scheduler_pkg.sv
// Shared definitions for the intpol2 job scheduler: FSM state codes, job outcome codes
// and core status bit positions.
// No ports; imported by intpol2_cmd_fifo users and intpol2_job_scheduler.
package intpol2_job_scheduler_pkg;

   // Scheduler FSM states, kept as plain constants for legacy tool compatibility
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_ACK    = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;
   localparam logic [2:0] S_FLUSH  = 3'd6;

   typedef logic [1:0] job_status_t;

   localparam job_status_t JOB_OK      = 2'b00;
   localparam job_status_t JOB_TIMEOUT = 2'b01;
   localparam job_status_t JOB_ABORT   = 2'b10;

   // Bit positions inside the core status_reg
   localparam int ST_DONE  = 0;
   localparam int ST_BUSY  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_AFULL = 3;

endpackage

// File: rtl/intpol2_cmd_fifo.sv
// Synchronous job queue holding full 4-word config commands; read data is the head entry.
// Ports: clk/rst, clear_i (empties queue, wins over push/pop), push_i/wdata_i, pop_i,
//        rdata_o (head), level_o (entries held). Push is ignored when full, pop when empty.
module intpol2_cmd_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (level_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (level_q != '0);
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/intpol2_job_scheduler.sv
// Job sequencer for one intpol2_D4_CORE: queues config jobs, programs config_reg, pulses start,
// watches done/busy/stall with a watchdog and reports OK/TIMEOUT/ABORT per job id.
// Ports: host cmd_valid/cmd_ready/cmd_cfg, abort, timeout_limit; core core_status in,
//        config_reg/start/core_rst out; job_done_valid/job_status/job_id/sched_busy/queue_level.
module intpol2_job_scheduler
   import intpol2_job_scheduler_pkg::*;
#(
   parameter int CONFIG_WIDTH  = 32,
   parameter int QUEUE_DEPTH   = 4,
   parameter int QUEUE_AW      = 2,
   parameter int TIMEOUT_WIDTH = 24,
   parameter int FLUSH_CYCLES  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [4*CONFIG_WIDTH-1:0] cmd_cfg,
   input  logic                      abort,
   input  logic [TIMEOUT_WIDTH-1:0]  timeout_limit,
   input  logic [7:0]                core_status,
   output logic [4*CONFIG_WIDTH-1:0] config_reg,
   output logic                      start,
   output logic                      core_rst,
   output logic                      job_done_valid,
   output logic [1:0]                job_status,
   output logic [7:0]                job_id,
   output logic                      sched_busy,
   output logic [QUEUE_AW:0]         queue_level
);

   localparam int CW = 4*CONFIG_WIDTH;
   localparam int FW = $clog2(FLUSH_CYCLES+1);

   logic [2:0]               state_q, state_d;
   logic [CW-1:0]            cfg_q, cfg_d;
   logic [7:0]               id_q, id_d;
   job_status_t              status_q, status_d;
   job_status_t              fail_q, fail_d;
   logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
   logic [FW-1:0]            fl_q, fl_d;
   logic                     done_prev_q;

   logic [CW-1:0]            head;
   logic                     push;
   logic                     pop;
   logic                     done_rise;
   logic                     stalled;
   logic                     wd_expired;
   logic                     unused_status;

   assign unused_status = ^core_status[7:4];

   assign cmd_ready = (queue_level != (QUEUE_AW+1)'(QUEUE_DEPTH));
   assign push      = cmd_valid && cmd_ready;

   // abort empties the queue and discards a same-cycle push
   intpol2_cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (QUEUE_DEPTH),
      .AW    (QUEUE_AW)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (abort),
      .push_i  (push),
      .wdata_i (cmd_cfg),
      .pop_i   (pop),
      .rdata_o (head),
      .level_o (queue_level)
   );

   assign done_rise  = core_status[ST_DONE] && !done_prev_q;
   // FIFO stalls inside the core are legal waits, not lack of progress
   assign stalled    = core_status[ST_EMPTY] || core_status[ST_AFULL];
   assign wd_expired = (timeout_limit != '0) && (wd_q == timeout_limit);

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      id_d     = id_q;
      status_d = status_q;
      fail_d   = fail_q;
      wd_d     = wd_q;
      fl_d     = fl_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((queue_level != '0) && !abort) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // The job is loaded and numbered even if aborted here, so the
            // ABORT report carries the id of the job that was killed.
            pop   = 1'b1;
            cfg_d = head;
            id_d  = id_q + 8'd1;
            wd_d  = '0;
            if (abort) begin
               state_d = S_FLUSH;
               fail_d  = JOB_ABORT;
               fl_d    = '0;
            end else begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (abort) begin
               state_d = S_FLUSH;
               fail_d  = JOB_ABORT;
               fl_d    = '0;
            end else begin
               state_d = S_ACK;
            end
         end
         S_ACK, S_RUN: begin
            if (!stalled) begin
               wd_d = wd_q + TIMEOUT_WIDTH'(1);
            end
            // Priority: abort over done, done over watchdog expiry
            if (abort) begin
               state_d = S_FLUSH;
               fail_d  = JOB_ABORT;
               fl_d    = '0;
            end else if (done_rise) begin
               state_d  = S_REPORT;
               status_d = JOB_OK;
            end else if (wd_expired) begin
               state_d = S_FLUSH;
               fail_d  = JOB_TIMEOUT;
               fl_d    = '0;
            end else if ((state_q == S_ACK) && core_status[ST_BUSY]) begin
               state_d = S_RUN;
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            fl_d = fl_q + FW'(1);
            if (fl_q == FW'(FLUSH_CYCLES-1)) begin
               state_d  = S_REPORT;
               status_d = fail_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cfg_q       <= '0;
         id_q        <= '0;
         status_q    <= JOB_OK;
         fail_q      <= JOB_OK;
         wd_q        <= '0;
         fl_q        <= '0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         id_q        <= id_d;
         status_q    <= status_d;
         fail_q      <= fail_d;
         wd_q        <= wd_d;
         fl_q        <= fl_d;
         done_prev_q <= core_status[ST_DONE];
      end
   end

   assign config_reg     = cfg_q;
   assign start          = (state_q == S_START) && !abort;
   assign core_rst       = (state_q == S_FLUSH);
   assign job_done_valid = (state_q == S_REPORT);
   assign job_status     = status_q;
   assign job_id         = id_q;
   assign sched_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_intpol2_job_scheduler.sv
// Bench for intpol2_job_scheduler: a behavioural core responder, a monitor that logs starts,
// reports and core_rst pulses, and a directed/randomized job sequence checked against a
// transaction-level model (expected config order, id sequence and per-job outcome).
module tb_intpol2_job_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [127:0] cmd_cfg;
   logic         abort;
   logic [23:0]  timeout_limit;
   logic [7:0]   core_status;
   logic [127:0] config_reg;
   logic         start;
   logic         core_rst;
   logic         job_done_valid;
   logic [1:0]   job_status;
   logic [7:0]   job_id;
   logic         sched_busy;
   logic [2:0]   queue_level;

   intpol2_job_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_cfg        (cmd_cfg),
      .abort          (abort),
      .timeout_limit  (timeout_limit),
      .core_status    (core_status),
      .config_reg     (config_reg),
      .start          (start),
      .core_rst       (core_rst),
      .job_done_valid (job_done_valid),
      .job_status     (job_status),
      .job_id         (job_id),
      .sched_busy     (sched_busy),
      .queue_level    (queue_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int delay;
      int stall;
      bit hang;
   } beh_t;

   beh_t         beh_q[$];
   logic [127:0] exp_cfg_q[$];
   logic [127:0] started_q[$];
   logic [9:0]   exp_rep_q[$];
   logic [9:0]   rep_q[$];
   int           rst_len_q[$];

   int   checks = 0;
   int   failures = 0;
   int   n_starts = 0;
   int   cfg_bad = 0;
   int   next_id = 1;
   bit   auto_core = 1'b1;
   logic [7:0] auto_st = 8'h00;
   logic [7:0] man_st = 8'h00;

   assign core_status = auto_core ? auto_st : man_st;

   // Core responder: busy two cycles after start, done pulse at +delay, optional stall window
   initial begin
      int   cnt;
      bit   act;
      beh_t b;
      act = 1'b0;
      cnt = 0;
      b = '{20, 0, 1'b0};
      forever begin
         @(negedge clk);
         #2;
         if (!auto_core || rst || core_rst) begin
            act = 1'b0;
            auto_st = 8'h00;
         end else if (start) begin
            if (beh_q.size() > 0) b = beh_q.pop_front();
            else b = '{20, 0, 1'b0};
            act = 1'b1;
            cnt = 0;
            auto_st = 8'h00;
         end else if (act) begin
            cnt++;
            auto_st = 8'h00;
            auto_st[1] = (cnt >= 2);
            auto_st[2] = (cnt < b.stall);
            if (!b.hang && cnt == b.delay) begin
               auto_st[0] = 1'b1;
               act = 1'b0;
            end
         end else begin
            auto_st = 8'h00;
         end
      end
   end

   // Monitor: logs starts, reports, core_rst pulse lengths, and config_reg stability per job
   initial begin
      logic [127:0] cur;
      bit in_job;
      int rl;
      in_job = 1'b0;
      rl = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            in_job = 1'b0;
            rl = 0;
         end else begin
            if (start) begin
               n_starts++;
               started_q.push_back(config_reg);
               cur = config_reg;
               in_job = 1'b1;
            end else if (in_job && config_reg !== cur) begin
               cfg_bad++;
            end
            if (job_done_valid) begin
               rep_q.push_back({job_status, job_id});
               in_job = 1'b0;
            end
            if (core_rst) rl++;
            else if (rl > 0) begin
               rst_len_q.push_back(rl);
               rl = 0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout observed=no_finish expected=finish");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic add_beh(input int delay, input int stall, input bit hang);
      beh_q.push_back('{delay, stall, hang});
   endtask

   function automatic logic [127:0] rand_cfg();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic expect_rep(input logic [1:0] st);
      exp_rep_q.push_back({st, 8'(next_id)});
      next_id = (next_id + 1) % 256;
   endtask

   // Called at a negedge; returns at the negedge after the accepting clock edge
   task automatic push_job(input logic [127:0] c);
      int k;
      k = 0;
      cmd_cfg = c;
      cmd_valid = 1'b1;
      while (!cmd_ready && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("push_accept", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_cfg_q.push_back(c);
   endtask

   task automatic wait_starts(input int target, input int budget);
      int k;
      k = 0;
      while (n_starts < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("start_seen", n_starts >= target, 1'b1);
   endtask

   task automatic wait_reps(input int budget);
      int k;
      logic [9:0] e;
      logic [9:0] g;
      k = 0;
      while (rep_q.size() < exp_rep_q.size() && k < budget) begin
         @(negedge clk);
         k++;
      end
      cycles(2);
      chk("report_count", rep_q.size(), exp_rep_q.size());
      while (exp_rep_q.size() > 0 && rep_q.size() > 0) begin
         e = exp_rep_q.pop_front();
         g = rep_q.pop_front();
         chk("report_status", g[9:8], e[9:8]);
         chk("report_id", g[7:0], e[7:0]);
      end
      exp_rep_q.delete();
      rep_q.delete();
   endtask

   task automatic check_started();
      chk("start_count", started_q.size(), exp_cfg_q.size());
      while (started_q.size() > 0 && exp_cfg_q.size() > 0) begin
         chk("start_cfg", started_q.pop_front(), exp_cfg_q.pop_front());
      end
      started_q.delete();
      exp_cfg_q.delete();
      chk("cfg_stable", cfg_bad, 0);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_cmd_ready"}, cmd_ready, 1'b1);
      chk({p, "_config_reg"}, config_reg, 128'h0);
      chk({p, "_start"}, start, 1'b0);
      chk({p, "_core_rst"}, core_rst, 1'b0);
      chk({p, "_job_done_valid"}, job_done_valid, 1'b0);
      chk({p, "_job_status"}, job_status, 2'b00);
      chk({p, "_job_id"}, job_id, 8'h00);
      chk({p, "_sched_busy"}, sched_busy, 1'b0);
      chk({p, "_queue_level"}, queue_level, 3'd0);
   endtask

   initial begin
      logic [127:0] c;
      int s0;
      int s1;
      bit h;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_cfg = '0;
      abort = 1'b0;
      timeout_limit = '0;
      cycles(2);
      rst = 1'b0;
      @(negedge clk);
      chk_reset("reset");

      // Single job: exact start latency, OK report with id 1, config retained afterwards
      add_beh(40, 0, 1'b0);
      c = {32'd16, 32'h0, 32'h100, 32'h2};
      push_job(c);
      @(negedge clk);
      chk("start_before_t2", start, 1'b0);
      @(negedge clk);
      chk("start_at_t2", start, 1'b1);
      chk("cfg_at_start", config_reg, c);
      expect_rep(2'b00);
      wait_reps(200);
      chk("single_start_count", n_starts, 1);
      chk("cfg_retained", config_reg, c);
      chk("idle_after_job", sched_busy, 1'b0);

      // Fill the queue behind a running job; the sixth push must wait for a LOAD
      for (int i = 0; i < 6; i++) add_beh(int'($urandom_range(40, 60)), 0, 1'b0);
      push_job(rand_cfg());
      cycles(5);
      for (int i = 0; i < 4; i++) push_job(rand_cfg());
      chk("full_level", queue_level, 3'd4);
      chk("full_ready", cmd_ready, 1'b0);
      push_job(rand_cfg());
      for (int i = 0; i < 6; i++) expect_rep(2'b00);
      wait_reps(1500);

      // Watchdog: hung job times out with a four-cycle core_rst, next job still runs
      timeout_limit = 24'd50;
      add_beh(0, 0, 1'b1);
      add_beh(30, 0, 1'b0);
      push_job(rand_cfg());
      push_job(rand_cfg());
      expect_rep(2'b01);
      expect_rep(2'b00);
      wait_reps(600);
      chk("timeout_flush_count", rst_len_q.size(), 1);
      if (rst_len_q.size() > 0) chk("timeout_flush_len", rst_len_q[0], 4);
      rst_len_q.delete();

      // Long stall window is not counted by the watchdog
      add_beh(210, 200, 1'b0);
      push_job(rand_cfg());
      expect_rep(2'b00);
      wait_reps(600);
      chk("stall_no_flush", rst_len_q.size(), 0);
      rst_len_q.delete();

      // Abort during RUN with two jobs queued, plus a push in the abort cycle
      timeout_limit = '0;
      add_beh(100, 0, 1'b0);
      add_beh(20, 0, 1'b0);
      add_beh(20, 0, 1'b0);
      s0 = n_starts;
      push_job(rand_cfg());
      wait_starts(s0 + 1, 50);
      cycles(10);
      push_job(rand_cfg());
      push_job(rand_cfg());
      chk("abort_pre_level", queue_level, 3'd2);
      abort = 1'b1;
      cmd_valid = 1'b1;
      cmd_cfg = rand_cfg();
      @(negedge clk);
      abort = 1'b0;
      cmd_valid = 1'b0;
      chk("abort_level", queue_level, 3'd0);
      chk("abort_ready", cmd_ready, 1'b1);
      void'(exp_cfg_q.pop_back());
      void'(exp_cfg_q.pop_back());
      void'(beh_q.pop_back());
      void'(beh_q.pop_back());
      expect_rep(2'b10);
      wait_reps(100);
      s1 = n_starts;
      cycles(40);
      chk("abort_no_more_starts", n_starts, s1);
      chk("abort_idle", sched_busy, 1'b0);
      chk("abort_flush_count", rst_len_q.size(), 1);
      if (rst_len_q.size() > 0) chk("abort_flush_len", rst_len_q[0], 4);
      rst_len_q.delete();

      // Done and abort in the same cycle: abort wins
      auto_core = 1'b0;
      man_st = 8'h00;
      s0 = n_starts;
      push_job(rand_cfg());
      wait_starts(s0 + 1, 50);
      man_st = 8'h02;
      cycles(5);
      man_st = 8'h03;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      man_st = 8'h00;
      expect_rep(2'b10);
      wait_reps(100);
      auto_core = 1'b1;
      rst_len_q.delete();

      // Randomized mix of completing and hung jobs under a watchdog
      timeout_limit = 24'd40;
      for (int i = 0; i < 6; i++) begin
         h = ($urandom_range(0, 2) == 0);
         add_beh(int'($urandom_range(3, 30)), 0, h);
         push_job(rand_cfg());
         expect_rep(h ? 2'b01 : 2'b00);
         cycles(int'($urandom_range(0, 8)));
      end
      wait_reps(1500);
      rst_len_q.delete();
      timeout_limit = '0;

      // Reset mid-RUN drops everything; the next job restarts at id 1
      add_beh(100, 0, 1'b0);
      s0 = n_starts;
      push_job(rand_cfg());
      wait_starts(s0 + 1, 50);
      cycles(10);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("midrun_reset");
      rst = 1'b0;
      beh_q.delete();
      next_id = 1;
      @(negedge clk);
      add_beh(20, 0, 1'b0);
      push_job(rand_cfg());
      expect_rep(2'b00);
      wait_reps(200);
      check_started();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
